// File: rtl/dsi_pkg.sv
// Shared types and constants for the DSI link power sequencer.
package dsi_pkg;

    localparam int DSI_SEQ_TMO_W_DEFAULT = 16;

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_CLK_START   = 3'd1,
        ST_SETTLE      = 3'd2,
        ST_LINES_START = 3'd3,
        ST_STREAM      = 3'd4,
        ST_DRAIN       = 3'd5,
        ST_LINES_STOP  = 3'd6,
        ST_CLK_STOP    = 3'd7
    } dsi_link_state_t;

    // States that wait on a dsi_core handshake and are guarded by the timeout.
    function automatic logic dsi_is_wait(input dsi_link_state_t s);
        return (s == ST_CLK_START) || (s == ST_LINES_START) || (s == ST_DRAIN) ||
               (s == ST_LINES_STOP) || (s == ST_CLK_STOP);
    endfunction

endpackage

// File: rtl/dsi_down_counter.sv
// Loadable down counter that saturates at zero; zero flag is combinational.
module dsi_down_counter #(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_value,
    input  logic             i_en,
    output logic             o_zero
);
    logic [WIDTH-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n)
            r_cnt <= '0;
        else if (i_load)
            r_cnt <= i_value;
        else if (i_en && (r_cnt != '0))
            r_cnt <= r_cnt - 1'b1;
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/dsi_link_sequencer.sv
// Link power-up/down sequencer driving the dsi_core clock/lines/streaming enables.
module dsi_link_sequencer
    import dsi_pkg::*;
#(
    parameter int TMO_W    = DSI_SEQ_TMO_W_DEFAULT,
    parameter int SETTLE_W = 8
) (
    input  logic                sys_clk,
    input  logic                sys_rst_n,
    input  logic                link_start,
    input  logic [TMO_W-1:0]    timeout_cycles,
    input  logic [SETTLE_W-1:0] settle_cycles,
    input  logic                err_clear,
    input  logic                clock_ready,
    input  logic                lines_ready,
    input  logic                lines_active,
    input  logic [3:0]          lanes_fifo_empty,
    output logic                clock_enable,
    output logic                lines_enable,
    output logic                streaming_enable,
    output logic                link_up,
    output logic                busy,
    output logic                timeout_err,
    output logic [2:0]          state
);
    dsi_link_state_t r_state;
    dsi_link_state_t w_next;
    logic            r_tmo_armed;
    logic            r_clock_enable, r_lines_enable, r_streaming_enable;
    logic            r_link_up, r_busy, r_timeout_err;
    logic            w_tmo_zero, w_tmo_load, w_tmo_fire;
    logic            w_settle_zero, w_settle_load;
    logic [TMO_W-1:0]    w_tmo_value;
    logic [SETTLE_W-1:0] w_settle_value;

    // Counters are loaded with N-1 so the state is left on the edge after N cycles.
    assign w_tmo_value    = (timeout_cycles == '0) ? '0 : timeout_cycles - 1'b1;
    assign w_settle_value = (settle_cycles == '0)  ? '0 : settle_cycles - 1'b1;
    assign w_tmo_load     = (w_next != r_state) && dsi_is_wait(w_next);
    assign w_settle_load  = (r_state == ST_CLK_START) && (w_next == ST_SETTLE);

    dsi_down_counter #(.WIDTH(TMO_W)) u_tmo_cnt (
        .i_clk   (sys_clk),
        .i_rst_n (sys_rst_n),
        .i_load  (w_tmo_load),
        .i_value (w_tmo_value),
        .i_en    (dsi_is_wait(r_state)),
        .o_zero  (w_tmo_zero)
    );

    dsi_down_counter #(.WIDTH(SETTLE_W)) u_settle_cnt (
        .i_clk   (sys_clk),
        .i_rst_n (sys_rst_n),
        .i_load  (w_settle_load),
        .i_value (w_settle_value),
        .i_en    (r_state == ST_SETTLE),
        .o_zero  (w_settle_zero)
    );

    always_comb begin
        w_next     = r_state;
        w_tmo_fire = 1'b0;
        case (r_state)
            ST_IDLE:        if (link_start && !r_timeout_err) w_next = ST_CLK_START;
            ST_CLK_START:   if (!link_start) w_next = ST_CLK_STOP;
                            else if (clock_ready) w_next = ST_SETTLE;
            ST_SETTLE:      if (!link_start) w_next = ST_LINES_STOP;
                            else if (w_settle_zero) w_next = ST_LINES_START;
            ST_LINES_START: if (!link_start) w_next = ST_LINES_STOP;
                            else if (lines_ready) w_next = ST_STREAM;
            ST_STREAM:      if (!link_start) w_next = ST_DRAIN;
            ST_DRAIN:       if ((&lanes_fifo_empty) && !lines_active) w_next = ST_LINES_STOP;
            ST_LINES_STOP:  if (!lines_ready) w_next = ST_CLK_STOP;
            ST_CLK_STOP:    if (!clock_ready) w_next = ST_IDLE;
            default:        w_next = ST_IDLE;
        endcase
        // A disarmed counter (timeout_cycles == 0) never fires.
        if (dsi_is_wait(r_state) && r_tmo_armed && w_tmo_zero && (w_next == r_state)) begin
            w_tmo_fire = 1'b1;
            w_next     = ST_IDLE;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            r_state            <= ST_IDLE;
            r_tmo_armed        <= 1'b0;
            r_clock_enable     <= 1'b0;
            r_lines_enable     <= 1'b0;
            r_streaming_enable <= 1'b0;
            r_link_up          <= 1'b0;
            r_busy             <= 1'b0;
            r_timeout_err      <= 1'b0;
        end else begin
            r_state            <= w_next;
            if (w_tmo_load)
                r_tmo_armed    <= (timeout_cycles != '0);
            r_clock_enable     <= (w_next != ST_IDLE) && (w_next != ST_CLK_STOP);
            r_lines_enable     <= (w_next == ST_LINES_START) || (w_next == ST_STREAM) ||
                                  (w_next == ST_DRAIN);
            r_streaming_enable <= (w_next == ST_STREAM);
            r_link_up          <= (w_next == ST_STREAM);
            r_busy             <= (w_next != ST_IDLE);
            if (w_tmo_fire)
                r_timeout_err  <= 1'b1;
            else if (err_clear)
                r_timeout_err  <= 1'b0;
        end
    end

    assign clock_enable     = r_clock_enable;
    assign lines_enable     = r_lines_enable;
    assign streaming_enable = r_streaming_enable;
    assign link_up          = r_link_up;
    assign busy             = r_busy;
    assign timeout_err      = r_timeout_err;
    assign state            = r_state;

endmodule
